bf_control: RTL and testbench
=============================

Name: bf_control

Overview:
- Fetch/decode/execute sequencer for the bf machine.
- Sits directly upstream of the PC, BCount, DP and DOut registers and drives their load/enable inputs and next-value buses.
- Reads the program memory addressed by PC and the data-cell memory addressed by DP.
- Performs bracket scanning using BCount, and handles console I/O handshakes.

Parameters:
ADDR_W, 16, width of PC/DP/DOut buses
CELL_W, 8, data cell and program byte width
BCOUNT_W, 8, bracket counter width
DMEM_DEPTH, 30000, data memory cells (used only with BF_DP_BOUND_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin execution from address 0
prog_data  in  CELL_W  program memory read data, 1-cycle sync read of address PC
pc  in  ADDR_W  current PC register value
pc_in  out  ADDR_W  next PC value
LdPC  out  1  PC load strobe
bcount  in  BCOUNT_W  BCount register value
BCountEnable  out  1  BCount step strobe
BCountDecInc  out  1  1 = decrement, 0 = increment
dp  in  ADDR_W  current DP register value
dp_in  out  ADDR_W  next DP value
DPEnable  out  1  DP load strobe
cell_rdata  in  CELL_W  data memory read data, 1-cycle sync read of address DP
cell_wdata  out  CELL_W  data memory write data
cell_we  out  1  data memory write strobe, address DP
DOutEnable  out  1  DOut load strobe (DOut in = zero-extended cell_rdata)
out_valid  out  1  output byte held in DOut is valid
out_ready  in  1  consumer accepts output byte
in_data  in  CELL_W  console input byte
in_valid  in  1  input byte available
in_ready  out  1  block ready to take input byte
busy  out  1  high in any state except IDLE/HALT
halted  out  1  program finished or error
error  out  1  sticky fault flag

Behaviour:
- Reset: all outputs 0; state IDLE. Reset asserted mid-instruction aborts with no further strobes.
- Strobes (LdPC, DPEnable, BCountEnable, cell_we, DOutEnable) are single-cycle pulses.
- States: IDLE, FETCH, EXEC, OUT_WAIT, IN_WAIT, SCAN_F_FETCH, SCAN_F, SCAN_B_FETCH, SCAN_B, HALT.
- IDLE/HALT: when start=1 and error=0, pulse LdPC with pc_in=0, go to FETCH. start is ignored in all other states.
- FETCH: one wait cycle for both memories, then EXEC.
- EXEC decodes prog_data:
  - '>' 0x3E: dp_in=dp+1, DPEnable.
  - '<' 0x3C: dp_in=dp-1, DPEnable. DP wraps modulo 2^ADDR_W.
  - '+' 0x2B / '-' 0x2D: cell_wdata=cell_rdata±1, modulo 2^CELL_W, cell_we.
  - '.' 0x2E: DOutEnable, go to OUT_WAIT.
  - ',' 0x2C: go to IN_WAIT.
  - '[' 0x5B with cell_rdata==0: BCount inc, go to SCAN_F_FETCH. With cell_rdata≠0: no-op.
  - ']' 0x5D with cell_rdata≠0: BCount inc, pc_in=pc-1, go to SCAN_B_FETCH. With cell_rdata==0: no-op.
  - 0x00: go to HALT, halted=1.
  - Any other byte: no-op.
- PC advance: every non-waiting, non-scan, non-halt EXEC pulses LdPC with pc_in=pc+1 and returns to FETCH. Plain instruction = 2 cycles.
- OUT_WAIT: out_valid=1 until the cycle out_ready=1; that cycle pulses LdPC with pc+1 and goes to FETCH.
- IN_WAIT: in_ready=1. On in_valid=1: cell_wdata=in_data, cell_we, LdPC pc+1, go to FETCH.
- SCAN_F (entered after a 1-cycle fetch, PC already +1):
  - '[': BCount inc.
  - ']': BCount dec; if bcount==1, pc+1 and go to FETCH (match).
  - 0x00: error=1, go to HALT.
  - Otherwise pc+1 and go to SCAN_F_FETCH.
- SCAN_B mirrors SCAN_F:
  - ']': inc.
  - '[': dec; if bcount==1, pc_in=pc+1 and go to FETCH.
  - Otherwise pc-1.
  - pc==0 without a match: error, HALT.
- Invariant: bcount==0 outside scans.
- Inc with bcount all-ones: error, HALT (nesting overflow).
- halted and error are cleared only by reset. A halted state without error restarts on start.

Optional Feature:
BF_DP_BOUND_EN
- Defined: '>' at dp==DMEM_DEPTH-1 or '<' at dp==0 sets error, goes to HALT, and issues no DPEnable.
- Undefined: DP wraps silently and DMEM_DEPTH is unused.

Decomposition:
- bf_pkg holds:
  - Opcode localparams: OP_RIGHT, OP_LEFT, OP_INC, OP_DEC, OP_OUT, OP_IN, OP_JZ, OP_JNZ, OP_END.
  - State enum encoding.
- Sub-module bf_decode: combinational byte-to-one-hot opcode classifier, shared by the EXEC and SCAN paths.

Test Plan:
- Program "++." then 0x00, out_ready=1:
  - One DOutEnable with cell 0x02 and a single out_valid cycle.
  - halted=1 with PC=3.
  - Plain instructions take 2 cycles each.
- Program "[+++]" then 0x00, cell=0:
  - Scan skips to PC=5 with no cell_we.
  - BCount returns to 0.
  - halted, error=0.
- Program "++[->+<]" then 0x00:
  - Loop runs twice; final cell0=0, cell1=2.
  - Backward scans land on PC=3.
- Program "," with in_valid held low 10 cycles, then in_data=0x41:
  - in_ready high throughout the wait.
  - cell0=0x41 one cycle after in_valid.
- Program "[" then 0x00, cell=0: error=1, halted=1.
- Reset pulled low during OUT_WAIT: all outputs 0 immediately and state IDLE. With BF_DP_BOUND_EN, "<" at dp=0: error, DP unchanged.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared opcodes, state encoding and decoded-opcode type for the bf sequencer
package bf_pkg;

    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT_WAIT,
        S_IN_WAIT,
        S_SCAN_F_FETCH,
        S_SCAN_F,
        S_SCAN_B_FETCH,
        S_SCAN_B,
        S_HALT
    } state_t;

    // One-hot opcode class; all fields zero means "no-op byte".
    typedef struct packed {
        logic right;
        logic left;
        logic inc;
        logic dec;
        logic out;
        logic inp;
        logic jz;
        logic jnz;
        logic stop;
    } op_t;

endpackage

// File: rtl/bf_control_if.sv
// rtl/bf_control_if.sv - console output/input handshake bundle between the sequencer and the console
interface bf_control_if #(
    parameter int CELL_W = 8
);
    logic              out_valid;
    logic              out_ready;
    logic [CELL_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output out_valid,
        input  out_ready,
        input  in_data,
        input  in_valid,
        output in_ready
    );

    modport slave (
        input  out_valid,
        output out_ready,
        output in_data,
        output in_valid,
        input  in_ready
    );
endinterface

// File: rtl/bf_decode.sv
// rtl/bf_decode.sv - combinational program-byte to one-hot opcode classifier
module bf_decode
    import bf_pkg::*;
#(
    parameter int CELL_W = 8
) (
    input  logic [CELL_W-1:0] code_i,
    output op_t               op_o
);

    always_comb begin
        op_o       = '0;
        op_o.right = (code_i == CELL_W'(OP_RIGHT));
        op_o.left  = (code_i == CELL_W'(OP_LEFT));
        op_o.inc   = (code_i == CELL_W'(OP_INC));
        op_o.dec   = (code_i == CELL_W'(OP_DEC));
        op_o.out   = (code_i == CELL_W'(OP_OUT));
        op_o.inp   = (code_i == CELL_W'(OP_IN));
        op_o.jz    = (code_i == CELL_W'(OP_JZ));
        op_o.jnz   = (code_i == CELL_W'(OP_JNZ));
        op_o.stop  = (code_i == CELL_W'(OP_END));
    end

endmodule

// File: rtl/bf_control.sv
// rtl/bf_control.sv - bf fetch/decode/execute sequencer driving PC, BCount, DP and DOut registers
// Optional BF_DP_BOUND_EN: '>' past DMEM_DEPTH-1 or '<' below 0 faults instead of wrapping DP.
module bf_control
    import bf_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int CELL_W   = 8,
    parameter int BCOUNT_W = 8
`ifdef BF_DP_BOUND_EN
    ,
    parameter int DMEM_DEPTH = 30000
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CELL_W-1:0]   prog_data,
    input  logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_in,
    output logic                LdPC,
    input  logic [BCOUNT_W-1:0] bcount,
    output logic                BCountEnable,
    output logic                BCountDecInc,
    input  logic [ADDR_W-1:0]   dp,
    output logic [ADDR_W-1:0]   dp_in,
    output logic                DPEnable,
    input  logic [CELL_W-1:0]   cell_rdata,
    output logic [CELL_W-1:0]   cell_wdata,
    output logic                cell_we,
    output logic                DOutEnable,
    bf_control_if.master        con,
    output logic                busy,
    output logic                halted,
    output logic                error
);

    state_t state_q, state_d;
    logic   halted_q, halted_d;
    logic   error_q, error_d;
    op_t    op;
    logic   fault;
    logic   out_valid;
    logic   in_ready;
    logic   bc_full;
    logic   bc_last;
    logic   cell_zero;
    logic   pc_zero;

    bf_decode #(.CELL_W(CELL_W)) u_decode (
        .code_i (prog_data),
        .op_o   (op)
    );

    assign bc_full   = (bcount == {BCOUNT_W{1'b1}});
    assign bc_last   = (bcount == BCOUNT_W'(1));
    assign cell_zero = (cell_rdata == '0);
    assign pc_zero   = (pc == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        error_d      = error_q;
        fault        = 1'b0;
        pc_in        = '0;
        LdPC         = 1'b0;
        dp_in        = '0;
        DPEnable     = 1'b0;
        BCountEnable = 1'b0;
        BCountDecInc = 1'b0;
        cell_wdata   = '0;
        cell_we      = 1'b0;
        DOutEnable   = 1'b0;
        out_valid    = 1'b0;
        in_ready     = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                // reset is included so nothing strobes while reset is held
                if (start && !error_q && reset) begin
                    LdPC    = 1'b1;
                    pc_in   = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: state_d = S_EXEC;

            S_EXEC: begin
                LdPC    = 1'b1;
                pc_in   = pc + ADDR_W'(1);
                state_d = S_FETCH;
                if (op.right) begin
`ifdef BF_DP_BOUND_EN
                    if (dp == ADDR_W'(DMEM_DEPTH - 1)) fault = 1'b1;
`endif
                    DPEnable = 1'b1;
                    dp_in    = dp + ADDR_W'(1);
                end else if (op.left) begin
`ifdef BF_DP_BOUND_EN
                    if (dp == '0) fault = 1'b1;
`endif
                    DPEnable = 1'b1;
                    dp_in    = dp - ADDR_W'(1);
                end else if (op.inc) begin
                    cell_we    = 1'b1;
                    cell_wdata = cell_rdata + CELL_W'(1);
                end else if (op.dec) begin
                    cell_we    = 1'b1;
                    cell_wdata = cell_rdata - CELL_W'(1);
                end else if (op.out) begin
                    LdPC       = 1'b0;
                    DOutEnable = 1'b1;
                    state_d    = S_OUT_WAIT;
                end else if (op.inp) begin
                    LdPC    = 1'b0;
                    state_d = S_IN_WAIT;
                end else if (op.jz) begin
                    if (cell_zero) begin
                        BCountEnable = 1'b1;
                        state_d      = S_SCAN_F_FETCH;
                    end
                end else if (op.jnz) begin
                    if (!cell_zero) begin
                        BCountEnable = 1'b1;
                        pc_in        = pc - ADDR_W'(1);
                        state_d      = S_SCAN_B_FETCH;
                    end
                end else if (op.stop) begin
                    LdPC     = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end

            S_OUT_WAIT: begin
                out_valid = 1'b1;
                if (con.out_ready) begin
                    LdPC    = 1'b1;
                    pc_in   = pc + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end

            S_IN_WAIT: begin
                in_ready = 1'b1;
                if (con.in_valid) begin
                    cell_we    = 1'b1;
                    cell_wdata = con.in_data;
                    LdPC       = 1'b1;
                    pc_in      = pc + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
            end

            S_SCAN_F_FETCH: state_d = S_SCAN_F;

            S_SCAN_F: begin
                LdPC    = 1'b1;
                pc_in   = pc + ADDR_W'(1);
                state_d = S_SCAN_F_FETCH;
                if (op.stop) begin
                    fault = 1'b1;
                end else if (op.jz) begin
                    if (bc_full) fault = 1'b1;
                    BCountEnable = 1'b1;
                end else if (op.jnz) begin
                    BCountEnable = 1'b1;
                    BCountDecInc = 1'b1;
                    if (bc_last) state_d = S_FETCH;
                end
            end

            S_SCAN_B_FETCH: state_d = S_SCAN_B;

            S_SCAN_B: begin
                LdPC    = 1'b1;
                pc_in   = pc - ADDR_W'(1);
                state_d = S_SCAN_B_FETCH;
                if (op.jz && bc_last) begin
                    BCountEnable = 1'b1;
                    BCountDecInc = 1'b1;
                    pc_in        = pc + ADDR_W'(1);
                    state_d      = S_FETCH;
                end else if (pc_zero) begin
                    fault = 1'b1;
                end else if (op.jz) begin
                    BCountEnable = 1'b1;
                    BCountDecInc = 1'b1;
                end else if (op.jnz) begin
                    if (bc_full) fault = 1'b1;
                    BCountEnable = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // A fault suppresses every strobe raised above for this cycle.
        if (fault) begin
            LdPC         = 1'b0;
            pc_in        = '0;
            DPEnable     = 1'b0;
            dp_in        = '0;
            BCountEnable = 1'b0;
            BCountDecInc = 1'b0;
            cell_we      = 1'b0;
            cell_wdata   = '0;
            error_d      = 1'b1;
            halted_d     = 1'b1;
            state_d      = S_HALT;
        end
    end

    assign con.out_valid = out_valid;
    assign con.in_ready  = in_ready;
    assign busy          = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted        = halted_q;
    assign error         = error_q;

endmodule

// File: tb/tb_bf_control.sv
// tb/tb_bf_control.sv - directed vector bench for bf_control with register and memory models
module tb_bf_control;

    localparam int LIMIT = 2000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  prog_data;
    logic [15:0] pc_r;
    logic [15:0] pc_in;
    logic        LdPC;
    logic [7:0]  bc_r;
    logic        BCountEnable;
    logic        BCountDecInc;
    logic [15:0] dp_r;
    logic [15:0] dp_in;
    logic        DPEnable;
    logic [7:0]  cell_rdata;
    logic [7:0]  cell_wdata;
    logic        cell_we;
    logic        DOutEnable;
    logic        busy;
    logic        halted;
    logic        error;

    logic [15:0] dout_r;
    logic [7:0]  pmem [0:255];
    logic [7:0]  dmem [0:65535];
    logic        ld_en   = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [7:0]  ld_val  = '0;
    int          we_n;
    int          dout_n;
    int          ov_n;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bf_control_if #(.CELL_W(8)) con ();

    bf_control dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .prog_data    (prog_data),
        .pc           (pc_r),
        .pc_in        (pc_in),
        .LdPC         (LdPC),
        .bcount       (bc_r),
        .BCountEnable (BCountEnable),
        .BCountDecInc (BCountDecInc),
        .dp           (dp_r),
        .dp_in        (dp_in),
        .DPEnable     (DPEnable),
        .cell_rdata   (cell_rdata),
        .cell_wdata   (cell_wdata),
        .cell_we      (cell_we),
        .DOutEnable   (DOutEnable),
        .con          (con),
        .busy         (busy),
        .halted       (halted),
        .error        (error)
    );

    // External PC/DP/BCount/DOut registers and the two synchronous-read memories
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r       <= '0;
            dp_r       <= '0;
            bc_r       <= '0;
            dout_r     <= '0;
            prog_data  <= '0;
            cell_rdata <= '0;
            we_n       <= 0;
            dout_n     <= 0;
            ov_n       <= 0;
            for (int i = 0; i < 65536; i++) dmem[i] <= 8'h00;
        end else begin
            if (LdPC)         pc_r <= pc_in;
            if (DPEnable)     dp_r <= dp_in;
            if (BCountEnable) bc_r <= BCountDecInc ? bc_r - 8'd1 : bc_r + 8'd1;
            if (DOutEnable) begin
                dout_r <= {8'h00, cell_rdata};
                dout_n <= dout_n + 1;
            end
            if (ld_en)        dmem[ld_addr] <= ld_val;
            else if (cell_we) dmem[dp_r]    <= cell_wdata;
            if (cell_we)       we_n <= we_n + 1;
            if (con.out_valid) ov_n <= ov_n + 1;
            prog_data  <= pmem[pc_r[7:0]];
            cell_rdata <= dmem[dp_r];
        end
    end

    typedef struct {
        string       prog;
        logic [7:0]  c0_init;
        int          cyc;
        logic [15:0] pc;
        logic [15:0] dp;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic        err;
        logic [7:0]  bc;
        int          we;
        int          dn;
        logic [15:0] dout;
        int          ov;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(string p, logic [7:0] ci, int cyc, logic [15:0] pcv, logic [15:0] dpv,
                                logic [7:0] c0, logic [7:0] c1, logic err, logic [7:0] bc,
                                int we, int dn, logic [15:0] dout, int ov);
        vec_t v;
        v.prog = p;  v.c0_init = ci; v.cyc = cyc; v.pc = pcv; v.dp = dpv;
        v.c0 = c0;   v.c1 = c1;      v.err = err; v.bc = bc;  v.we = we;
        v.dn = dn;   v.dout = dout;  v.ov = ov;
        return v;
    endfunction

    function automatic logic [63:0] all_outs();
        return {13'd0, LdPC, pc_in, BCountEnable, BCountDecInc, dp_in, DPEnable, cell_wdata,
                cell_we, DOutEnable, con.out_valid, con.in_ready, busy, halted, error};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic load_prog(string s);
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) pmem[i] = s[i];
    endtask

    task automatic poke(logic [15:0] a, logic [7:0] v);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_val = v;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // Pulses start and counts busy cycles until the sequencer leaves the busy states.
    task automatic run(output int n);
        n = 0;
        start = 1'b1;
        forever begin
            @(negedge clock);
            start = 1'b0;
            if (!busy || n > LIMIT) break;
            n++;
        end
    endtask

    initial begin
        int n;
        int hi;

        vecs[0]  = mk("++.",      8'h00,  9, 16'd3, 16'd0, 8'h02, 8'h00, 1'b0, 8'd0, 2, 1, 16'h0002, 1);
        vecs[1]  = mk("[+++]",    8'h00, 12, 16'd5, 16'd0, 8'h00, 8'h00, 1'b0, 8'd0, 0, 0, 16'h0000, 0);
        vecs[2]  = mk("++[->+<]", 8'h00, 38, 16'd8, 16'd0, 8'h00, 8'h02, 1'b0, 8'd0, 6, 0, 16'h0000, 0);
        vecs[3]  = mk("[",        8'h00,  4, 16'd1, 16'd0, 8'h00, 8'h00, 1'b1, 8'd1, 0, 0, 16'h0000, 0);
        vecs[4]  = mk("[",        8'h05,  4, 16'd1, 16'd0, 8'h05, 8'h00, 1'b0, 8'd0, 0, 0, 16'h0000, 0);
        vecs[5]  = mk("]",        8'h00,  4, 16'd1, 16'd0, 8'h00, 8'h00, 1'b0, 8'd0, 0, 0, 16'h0000, 0);
        vecs[6]  = mk("-",        8'h00,  4, 16'd1, 16'd0, 8'hFF, 8'h00, 1'b0, 8'd0, 1, 0, 16'h0000, 0);
`ifdef BF_DP_BOUND_EN
        vecs[7]  = mk("<+>",      8'h00,  2, 16'd0, 16'd0, 8'h00, 8'h00, 1'b1, 8'd0, 0, 0, 16'h0000, 0);
`else
        vecs[7]  = mk("<+>",      8'h00,  8, 16'd3, 16'd0, 8'h00, 8'h00, 1'b0, 8'd0, 1, 0, 16'h0000, 0);
`endif
        vecs[8]  = mk("[[]]",     8'h00, 10, 16'd4, 16'd0, 8'h00, 8'h00, 1'b0, 8'd0, 0, 0, 16'h0000, 0);
        vecs[9]  = mk("+]",       8'h00,  6, 16'd0, 16'd0, 8'h01, 8'h00, 1'b1, 8'd1, 1, 0, 16'h0000, 0);
        vecs[10] = mk(">>+.",     8'h00, 11, 16'd4, 16'd2, 8'h00, 8'h00, 1'b0, 8'd0, 1, 1, 16'h0001, 1);

        con.out_ready = 1'b1;
        con.in_valid  = 1'b0;
        con.in_data   = 8'h00;
        load_prog("");

        @(negedge clock);
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_outputs", all_outs(), 64'd0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            load_prog(vecs[i].prog);
            if (vecs[i].c0_init != 8'h00) poke(16'd0, vecs[i].c0_init);
            run(n);
            chk($sformatf("v%0d_cycles", i), n,             vecs[i].cyc);
            chk($sformatf("v%0d_pc", i),     pc_r,          vecs[i].pc);
            chk($sformatf("v%0d_dp", i),     dp_r,          vecs[i].dp);
            chk($sformatf("v%0d_cell0", i),  dmem[0],       vecs[i].c0);
            chk($sformatf("v%0d_cell1", i),  dmem[1],       vecs[i].c1);
            chk($sformatf("v%0d_error", i),  error,         vecs[i].err);
            chk($sformatf("v%0d_halted", i), halted,        1'b1);
            chk($sformatf("v%0d_bcount", i), bc_r,          vecs[i].bc);
            chk($sformatf("v%0d_we_n", i),   we_n,          vecs[i].we);
            chk($sformatf("v%0d_dout_n", i), dout_n,        vecs[i].dn);
            chk($sformatf("v%0d_dout", i),   dout_r,        vecs[i].dout);
            chk($sformatf("v%0d_ov_n", i),   ov_n,          vecs[i].ov);
        end

        // Console input: long wait with in_valid low, then a single byte
        do_reset();
        load_prog(",");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!con.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("in_ready_seen", con.in_ready, 1'b1);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (con.in_ready && !cell_we) hi++;
            @(negedge clock);
        end
        chk("in_ready_hold", hi, 10);
        con.in_valid = 1'b1;
        con.in_data  = 8'h41;
        @(negedge clock);
        con.in_valid = 1'b0;
        chk("in_cell0", dmem[0], 8'h41);
        chk("in_ready_drop", con.in_ready, 1'b0);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("in_pc", pc_r, 16'd1);
        chk("in_halted", {halted, error}, 2'b10);

        // Reset asserted while the sequencer waits for the console to take a byte
        do_reset();
        load_prog(".");
        con.out_ready = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!con.out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        hi = 0;
        for (int k = 0; k < 3; k++) begin
            if (con.out_valid) hi++;
            @(negedge clock);
        end
        chk("out_wait_hold", hi, 3);
        reset = 1'b0;
        #1;
        chk("abort_outputs", all_outs(), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        con.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("abort_idle", {busy, LdPC}, 2'b00);

        // Clean halt restarts on start and runs the program again
        run(n);
        chk("restart_first", {halted, error, dout_n[3:0]}, 6'b10_0001);
        run(n);
        chk("restart_second_cycles", n, 5);
        chk("restart_second_dout_n", dout_n, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
